rr_port_arbiter: RTL and testbench

Round-robin arbiter that shares one W-bit output channel among N requesters, each presenting a valid/ready stream of W-bit words with a burst-end marker. It sits in front of a shared datapath port (default 5 lanes of 10-bit words) and grants one requester at a time for a bounded burst. Output data is registered, so the shared channel sees a clean registered interface.

---
 rtl/rr_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_rr_port_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_port_arbiter.sv
// rtl/rr_port_arbiter.sv - round-robin burst arbiter sharing one registered output channel
//
// Purpose:
//   Shares one W-bit output channel among N requesters. Each requester
//   presents a valid/ready word stream with a burst-end marker. One requester
//   is granted at a time and keeps the grant until its burst ends, either on
//   its own last marker or after MAX_BURST beats. The next arbitration search
//   starts just above the requester that finished. Output data is registered.
//
// Parameters:
//   N          number of requesters (2..16)
//   W          data word width
//   MAX_BURST  maximum beats per grant (1..255)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_valid  [N]       per-requester word valid
//   req_data   [N*W]     requester i word at bits [i*W +: W]
//   req_last   [N]       per-requester last-word-of-burst marker
//   req_ready  [N]       word accepted this cycle (at most one bit set)
//   out_valid            registered output word valid
//   out_data   [W]       registered output word
//   out_src    [log2 N]  requester that produced out_data
//   out_last             out_data ends its burst
//   out_ready            downstream accepts out_data
//   burst_cnt  [16]      completed bursts, saturating (only with ARB_GRANT_CNT_EN)
//   busy                 high while a requester holds the grant
//
// Build option:
//   ARB_GRANT_CNT_EN  adds the burst_cnt output and its counter.

module rr_port_arbiter #(
   parameter int N         = 5,
   parameter int W         = 10,
   parameter int MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req_valid,
   input  logic [N*W-1:0]       req_data,
   input  logic [N-1:0]         req_last,
   output logic [N-1:0]         req_ready,
   output logic                 out_valid,
   output logic [W-1:0]         out_data,
   output logic [$clog2(N)-1:0] out_src,
   output logic                 out_last,
   input  logic                 out_ready,
`ifdef ARB_GRANT_CNT_EN
   output logic [15:0]          burst_cnt,
`endif
   output logic                 busy
);

   localparam int PW = $clog2(N);
   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] grant;
   logic [BW-1:0] beat_cnt;

   logic [PW-1:0] pick;
   logic          any_req;
   logic          accept;
   logic          beat_last;
   logic          burst_end;

   // Round-robin pick: candidates are visited from the farthest offset down
   // to offset 0, so the valid requester closest at-or-above rr_ptr is the
   // last one written and wins. The offset sum needs one extra bit because
   // rr_ptr + k can reach 2N-2 before wrapping.
   always_comb begin
      logic [PW:0]   sum;
      logic [PW-1:0] cand;
      any_req = 1'b0;
      pick    = '0;
      sum     = '0;
      cand    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr} + (PW + 1)'(k);
         if (sum >= (PW + 1)'(N)) begin
            sum = sum - (PW + 1)'(N);
         end
         cand = sum[PW-1:0];
         if (req_valid[cand]) begin
            any_req = 1'b1;
            pick    = cand;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (burst_end) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic. The granted ready is combinational from the output
   // register so a stalled output word blocks the next beat in the same cycle.
   always_comb begin
      req_ready = '0;
      busy      = 1'b0;
      if (state == GRANT) begin
         busy             = 1'b1;
         req_ready[grant] = !out_valid || out_ready;
      end
   end

   assign accept    = (state == GRANT) && req_valid[grant] && req_ready[grant];
   assign beat_last = req_last[grant] || (beat_cnt == BW'(MAX_BURST - 1));
   assign burst_end = accept && beat_last;

   // Grant bookkeeping and the registered output word
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         grant     <= '0;
         beat_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         out_last  <= 1'b0;
      end else begin
         if (state == IDLE && any_req) begin
            grant    <= pick;
            beat_cnt <= '0;
         end

         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= req_data[grant*W +: W];
            out_src   <= grant;
            out_last  <= beat_last;
            beat_cnt  <= beat_cnt + 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (burst_end) begin
            rr_ptr <= (grant == PW'(N - 1)) ? '0 : grant + 1'b1;
         end
      end
   end

`ifdef ARB_GRANT_CNT_EN
   // Completed-burst counter, sticks at all-ones
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         burst_cnt <= '0;
      end else if (burst_end && burst_cnt != 16'hFFFF) begin
         burst_cnt <= burst_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rr_port_arbiter.sv
// tb/tb_rr_port_arbiter.sv - self-checking bench for rr_port_arbiter

module tb_rr_port_arbiter;

   localparam int N         = 5;
   localparam int W         = 10;
   localparam int MAX_BURST = 4;
   localparam int PW        = $clog2(N);

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*W-1:0]  req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic            out_valid;
   logic [W-1:0]    out_data;
   logic [PW-1:0]   out_src;
   logic            out_last;
   logic            out_ready;
   logic            busy;
`ifdef ARB_GRANT_CNT_EN
   logic [15:0]     burst_cnt;
`endif

   rr_port_arbiter #(.N(N), .W(W), .MAX_BURST(MAX_BURST)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_last  (out_last),
      .out_ready (out_ready),
`ifdef ARB_GRANT_CNT_EN
      .burst_cnt (burst_cnt),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           src;
      logic [W-1:0] data;
      logic         last;
   } beat_t;

   logic [W:0]   lane_q [N][$];   // {last, data} words waiting at each requester
   beat_t        exp_q[$];        // expected output beats in delivery order
   int           xfer_cyc[$];     // cycle index of each output transfer
   logic [N-1:0] hold;            // force a requester's valid low
   int           mdl_ptr;
   int           mdl_bursts;
   bit           mdl_stuck;
   bit           rand_ready;
   int           cyc;
   int           n_assert;
   int           n_fail;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input int lane, input logic [W-1:0] d, input logic l);
      lane_q[lane].push_back({l, d});
   endtask

   function automatic bit lanes_empty();
      bit e = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (lane_q[i].size() != 0) e = 1'b0;
      end
      return e;
   endfunction

   task automatic drive();
      logic [W:0] f;
      for (int i = 0; i < N; i++) begin
         if (lane_q[i].size() > 0 && !hold[i]) begin
            f                  = lane_q[i][0];
            req_valid[i]       = 1'b1;
            req_data[i*W +: W] = f[W-1:0];
            req_last[i]        = f[W];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[i*W +: W] = '0;
            req_last[i]        = 1'b0;
         end
      end
   endtask

   // Burst-level reference: walk requesters round-robin from the model
   // pointer, draining each winner until its last marker or the beat cap.
   task automatic model_schedule();
      logic [W:0] m [N][$];
      logic [W:0] w;
      beat_t      b;
      int         l;
      int         beats;
      bit         ended;
      for (int i = 0; i < N; i++) m[i] = lane_q[i];
      while (!mdl_stuck) begin
         l = -1;
         for (int k = 0; k < N; k++) begin
            if (l < 0 && m[(mdl_ptr + k) % N].size() > 0) l = (mdl_ptr + k) % N;
         end
         if (l < 0) break;
         beats = 0;
         ended = 1'b0;
         while (!ended && m[l].size() > 0) begin
            w      = m[l].pop_front();
            beats++;
            ended  = w[W] || (beats == MAX_BURST);
            b.src  = l;
            b.data = w[W-1:0];
            b.last = ended;
            exp_q.push_back(b);
         end
         if (ended) begin
            mdl_ptr = (l + 1) % N;
            mdl_bursts++;
         end else begin
            mdl_stuck = 1'b1;
         end
      end
   endtask

   // One clock: snapshot handshakes at the falling edge, check any output
   // transfer against the model, then advance the sources after the rise.
   task automatic tick();
      logic [N-1:0] fire;
      logic         ofire;
      beat_t        b;
      @(negedge clk);
      fire  = req_valid & req_ready;
      ofire = out_valid && out_ready;
      if (rst_n === 1'b1 && ofire === 1'b1) begin
         xfer_cyc.push_back(cyc);
         check("beat_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            check("out_src", 32'(out_src), b.src);
            check("out_data", 32'(out_data), 32'(b.data));
            check("out_last", 32'(out_last), 32'(b.last));
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (fire[i] === 1'b1 && lane_q[i].size() > 0) lane_q[i].delete(0);
      end
      if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
      drive();
      cyc++;
      #1;
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < N; i++) lane_q[i].delete();
      exp_q.delete();
      hold  = '0;
      rst_n = 1'b0;
      drive();
      for (int i = 0; i < cycles; i++) tick();
      rst_n      = 1'b1;
      mdl_ptr    = 0;
      mdl_bursts = 0;
      mdl_stuck  = 1'b0;
   endtask

   task automatic run_drain(input string tag, input int bound);
      for (int i = 0; i < bound; i++) begin
         if (exp_q.size() == 0 && lanes_empty() && out_valid === 1'b0) break;
         tick();
      end
      check(tag, exp_q.size(), 0);
   endtask

   task automatic wait_valid(input string tag, input int bound);
      for (int i = 0; i < bound; i++) begin
         if (out_valid === 1'b1) break;
         tick();
      end
      check(tag, 32'(out_valid), 1);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 0);
      check({tag, "_out_data"}, 32'(out_data), 0);
      check({tag, "_out_src"}, 32'(out_src), 0);
      check({tag, "_out_last"}, 32'(out_last), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_req_ready"}, 32'(req_ready), 0);
   endtask

   initial begin
      int cap_gap [5];
      n_assert   = 0;
      n_fail     = 0;
      cyc        = 0;
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      hold       = '0;
      req_valid  = '0;
      req_data   = '0;
      req_last   = '0;
      rst_n      = 1'b0;

      do_reset(2);
      check_reset_state("reset");

      // Single lane: three words from lane 2, last on the third
      push(2, 10'h001, 1'b0);
      push(2, 10'h002, 1'b0);
      push(2, 10'h003, 1'b1);
      model_schedule();
      drive();
      tick();
      check("single_busy_t1", 32'(busy), 1);
      check("single_ready_t1", 32'(req_ready), 32'b00100);
      check("single_valid_t1", 32'(out_valid), 0);
      tick();
      check("single_valid_t2", 32'(out_valid), 1);
      check("single_data_t2", 32'(out_data), 32'h001);
      check("single_src_t2", 32'(out_src), 2);
      check("single_last_t2", 32'(out_last), 0);
      tick();
      check("single_data_t3", 32'(out_data), 32'h002);
      check("single_last_t3", 32'(out_last), 0);
      tick();
      check("single_data_t4", 32'(out_data), 32'h003);
      check("single_last_t4", 32'(out_last), 1);
      tick();
      check("single_valid_t5", 32'(out_valid), 0);
      check("single_busy_t5", 32'(busy), 0);
      check("single_drained", exp_q.size(), 0);

      // Contention: lanes 0,1,4 with one-word bursts, two rounds each
      xfer_cyc.delete();
      for (int r = 0; r < 2; r++) begin
         push(0, 10'(10'h100 + r), 1'b1);
         push(1, 10'(10'h110 + r), 1'b1);
         push(4, 10'(10'h140 + r), 1'b1);
      end
      model_schedule();
      drive();
      run_drain("contend_drain", 60);
      check("contend_beats", xfer_cyc.size(), 6);
      for (int i = 1; i < xfer_cyc.size(); i++) begin
         check($sformatf("contend_gap%0d", i), xfer_cyc[i] - xfer_cyc[i-1], 2);
      end

      // Burst cap: six unmarked words from lane 3, released after four
      xfer_cyc.delete();
      for (int i = 0; i < 6; i++) push(3, 10'(10'h030 + i), 1'b0);
      model_schedule();
      drive();
      run_drain("cap_drain", 40);
      check("cap_beats", xfer_cyc.size(), 6);
      cap_gap = '{0, 1, 1, 1, 2};
      for (int i = 1; i < xfer_cyc.size() && i < 5; i++) begin
         check($sformatf("cap_gap%0d", i), xfer_cyc[i] - xfer_cyc[i-1], cap_gap[i]);
      end
      check("cap_waiting", 32'(busy), 32'(mdl_stuck));
      check("cap_idle_out", 32'(out_valid), 0);
      do_reset(1);
      check_reset_state("cap_reset");

      // Backpressure: stall three cycles after the second word, then drop
      // valid for two cycles while the grant is held
      for (int i = 0; i < 4; i++) push(1, 10'(10'h010 + i), i == 3);
      model_schedule();
      drive();
      wait_valid("bp_first_valid", 10);
      check("bp_first_data", 32'(out_data), 32'h010);
      tick();
      check("bp_second_data", 32'(out_data), 32'h011);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 1);
         check($sformatf("bp_hold_data%0d", i), 32'(out_data), 32'h011);
         check($sformatf("bp_hold_ready%0d", i), 32'(req_ready), 0);
      end
      out_ready = 1'b1;
      hold[1]   = 1'b1;
      drive();
      for (int i = 0; i < 2; i++) begin
         tick();
         check($sformatf("gap_valid%0d", i), 32'(out_valid), 0);
         check($sformatf("gap_busy%0d", i), 32'(busy), 1);
      end
      hold = '0;
      drive();
      run_drain("bp_drain", 20);

      // Reset mid-burst after two beats; lane 0 must then beat lane 3
      for (int i = 0; i < 4; i++) push(2, 10'(10'h020 + i), 1'b0);
      model_schedule();
      drive();
      wait_valid("mid_first_valid", 10);
      tick();
      check("mid_second_data", 32'(out_data), 32'h021);
      do_reset(1);
      check("mid_out_valid", 32'(out_valid), 0);
      check("mid_busy", 32'(busy), 0);
      check("mid_req_ready", 32'(req_ready), 0);
      xfer_cyc.delete();
      push(0, 10'h040, 1'b1);
      push(3, 10'h043, 1'b1);
      model_schedule();
      drive();
      run_drain("mid_drain", 20);
      check("mid_beats", xfer_cyc.size(), 2);

      // Random traffic with random downstream stalls
      rand_ready = 1'b1;
      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < N; i++) begin
            int cnt;
            cnt = $urandom_range(0, 6);
            for (int j = 0; j < cnt; j++) begin
               push(i, W'($urandom), (j == cnt - 1) || ($urandom_range(0, 3) == 0));
            end
         end
         model_schedule();
         drive();
         run_drain($sformatf("rand_drain%0d", r), 300);
         check($sformatf("rand_idle%0d", r), 32'(busy), 0);
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      drive();

`ifdef ARB_GRANT_CNT_EN
      check("burst_cnt", 32'(burst_cnt), mdl_bursts);
      do_reset(1);
      check("burst_cnt_reset", 32'(burst_cnt), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
